// File: rtl/plic_pkg.sv
// plic_pkg: register map offsets, AXI channel FSM states and the
// register address decoder shared by the priority_plic files.
package plic_pkg;

    localparam logic [15:0] PRIO_BASE     = 16'h0000;
    localparam logic [15:0] PENDING_BASE  = 16'h1000;
    localparam logic [15:0] TRIGGER_BASE  = 16'h1080;
    localparam logic [15:0] ENABLE_BASE   = 16'h2000;
    localparam logic [15:0] ENABLE_STRIDE = 16'h0080;
    localparam logic [15:0] CTX_BASE      = 16'h8000;
    localparam logic [15:0] CTX_STRIDE    = 16'h0100;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } read_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRIO,
        REG_PEND,
        REG_TRIG,
        REG_EN,
        REG_THR,
        REG_CLAIM
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t   kind;
        logic [5:0]  id;
        logic        hi;
        logic [2:0]  ctx;
    } reg_sel_t;

    // w is the word address (byte address bits 15:2).
    // Range checks on id and ctx are left to the caller.
    function automatic reg_sel_t decode(input logic [13:0] w);
        reg_sel_t s;
        s.kind = REG_NONE;
        s.id   = w[5:0];
        s.hi   = w[0];
        s.ctx  = '0;
        unique case (1'b1)
            (w[13:6] == PRIO_BASE[15:8]): s.kind = REG_PRIO;
            (w[13:1] == PENDING_BASE[15:3]): s.kind = REG_PEND;
            (w[13:1] == TRIGGER_BASE[15:3]): s.kind = REG_TRIG;
            (w[13:8] == ENABLE_BASE[15:10] && w[4:1] == 4'd0): begin
                s.kind = REG_EN;
                s.ctx  = w[7:5];
            end
            (w[13:9] == CTX_BASE[15:11] && w[5:0] == 6'd0): begin
                s.kind = REG_THR;
                s.ctx  = w[8:6];
            end
            (w[13:9] == CTX_BASE[15:11] && w[5:0] == 6'd1): begin
                s.kind = REG_CLAIM;
                s.ctx  = w[8:6];
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway (level or rising-edge).
// Ports: clk, rst_n, irq, trigger, claim_clr, complete_clr -> pending, in_flight.
module plic_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic trigger,
    input  logic claim_clr,
    input  logic complete_clr,
    output logic pending,
    output logic in_flight
);

    logic irq_q;
    logic edge_set;
    logic level_set;

    // An edge beats a same-cycle claim; a level never re-pends on the
    // claim cycle because the source is about to go in-flight.
    assign edge_set  = trigger & irq & ~irq_q;
    assign level_set = ~trigger & irq & ~in_flight & ~claim_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= 1'b0;
            pending   <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            irq_q     <= irq;
            pending   <= edge_set | level_set | (pending & ~claim_clr);
            in_flight <= claim_clr | (in_flight & ~complete_clr);
        end
    end

endmodule

// File: rtl/priority_plic.sv
// priority_plic: AXI4-Lite programmed PLIC with per-context arbitration.
// Ports: ACLK/ARESETn, irq sources, eip per context, AXI4-Lite slave.
module priority_plic
    import plic_pkg::*;
#(
    parameter int NUM_SOURCES  = 31,
    parameter int PRIO_BITS    = 3,
    parameter int NUM_CONTEXTS = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_SOURCES-1:0]  irq,
    output logic [NUM_CONTEXTS-1:0] eip,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [15:0]             AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [15:0]             ARADDR,
    input  logic [2:0]              ARPROT,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP
);

    localparam logic [63:0] SRC_MASK =
        (((64'd1 << NUM_SOURCES) - 64'd1) << 1);

    logic [PRIO_BITS-1:0] prio_q [1:NUM_SOURCES];
    logic [63:0]          trig_q;
    logic [63:0]          en_q [NUM_CONTEXTS];
    logic [PRIO_BITS-1:0] thr_q [NUM_CONTEXTS];

    logic [63:0]            pend;
    logic [NUM_SOURCES:1]   infl;
    logic [NUM_SOURCES:1]   claim_clr;
    logic [NUM_SOURCES:1]   complete_clr;
    logic [NUM_SOURCES:1]   cmp_en;
    logic [5:0]             best_id [NUM_CONTEXTS];
    logic [PRIO_BITS-1:0]   best_pri [NUM_CONTEXTS];
    logic [5:0]             claim_id;

    write_state_t wstate;
    read_state_t  rstate;
    reg_sel_t     aw_sel;
    reg_sel_t     ar_sel;
    logic         wr_hs;
    logic         rd_hs;
    logic [31:0]  rd_word;

    logic unused;
    assign unused = ^{AWPROT, ARPROT, WSTRB, AWADDR[1:0],
                      ARADDR[1:0], infl};

    assign aw_sel = decode(AWADDR[15:2]);
    assign ar_sel = decode(ARADDR[15:2]);

    assign wr_hs   = (wstate == W_IDLE) & AWVALID & WVALID;
    assign AWREADY = wr_hs;
    assign WREADY  = wr_hs;
    assign ARREADY = (rstate == R_IDLE);
    assign rd_hs   = ARREADY & ARVALID;
    assign BRESP   = 2'b00;
    assign RRESP   = 2'b00;

    // Gateways
    assign pend[0] = 1'b0;
    for (genvar i = 1; i <= NUM_SOURCES; i++) begin : g_gw
        plic_gateway u_gw (
            .clk          (ACLK),
            .rst_n        (ARESETn),
            .irq          (irq[i-1]),
            .trigger      (trig_q[i]),
            .claim_clr    (claim_clr[i]),
            .complete_clr (complete_clr[i]),
            .pending      (pend[i]),
            .in_flight    (infl[i])
        );
    end
    if (NUM_SOURCES < 63) begin : g_hi
        assign pend[63:NUM_SOURCES+1] = '0;
    end

    // Strict '>' on best_pri keeps the lowest ID on a tie.
    always_comb begin
        for (int c = 0; c < NUM_CONTEXTS; c++) begin
            best_pri[c] = '0;
            best_id[c]  = '0;
            for (int i = 1; i <= NUM_SOURCES; i++) begin
                if (pend[i] && en_q[c][i] &&
                    (prio_q[i] > thr_q[c]) &&
                    (prio_q[i] > best_pri[c])) begin
                    best_pri[c] = prio_q[i];
                    best_id[c]  = 6'(i);
                end
            end
        end
    end

    // Claim/complete targets
    always_comb begin
        claim_id = '0;
        cmp_en   = '0;
        for (int c = 0; c < NUM_CONTEXTS; c++) begin
            if (ar_sel.kind == REG_CLAIM && ar_sel.ctx == 3'(c))
                claim_id = best_id[c];
            if (aw_sel.kind == REG_CLAIM && aw_sel.ctx == 3'(c))
                cmp_en = en_q[c][NUM_SOURCES:1];
        end
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            claim_clr[i]    = rd_hs && (claim_id == 6'(i));
            complete_clr[i] = wr_hs && (aw_sel.kind == REG_CLAIM) &&
                              (WDATA[5:0] == 6'(i)) && cmp_en[i];
        end
    end

    // Read mux (pre-write values)
    always_comb begin
        rd_word = '0;
        unique case (ar_sel.kind)
            REG_PRIO: begin
                for (int i = 1; i <= NUM_SOURCES; i++)
                    if (ar_sel.id == 6'(i)) rd_word = 32'(prio_q[i]);
            end
            REG_PEND: rd_word = ar_sel.hi ? pend[63:32] : pend[31:0];
            REG_TRIG: rd_word = ar_sel.hi ? trig_q[63:32] : trig_q[31:0];
            REG_EN: begin
                for (int c = 0; c < NUM_CONTEXTS; c++)
                    if (ar_sel.ctx == 3'(c))
                        rd_word = ar_sel.hi ? en_q[c][63:32] : en_q[c][31:0];
            end
            REG_THR: begin
                for (int c = 0; c < NUM_CONTEXTS; c++)
                    if (ar_sel.ctx == 3'(c)) rd_word = 32'(thr_q[c]);
            end
            REG_CLAIM: rd_word = 32'(claim_id);
            default: ;
        endcase
    end

    // Register file
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 1; i <= NUM_SOURCES; i++) prio_q[i] <= '0;
            trig_q <= '0;
            for (int c = 0; c < NUM_CONTEXTS; c++) begin
                en_q[c]  <= '0;
                thr_q[c] <= '0;
            end
        end else if (wr_hs) begin
            unique case (aw_sel.kind)
                REG_PRIO: begin
                    for (int i = 1; i <= NUM_SOURCES; i++)
                        if (aw_sel.id == 6'(i))
                            prio_q[i] <= WDATA[PRIO_BITS-1:0];
                end
                REG_TRIG: begin
                    if (aw_sel.hi) trig_q[63:32] <= WDATA & SRC_MASK[63:32];
                    else           trig_q[31:0]  <= WDATA & SRC_MASK[31:0];
                end
                REG_EN: begin
                    for (int c = 0; c < NUM_CONTEXTS; c++)
                        if (aw_sel.ctx == 3'(c)) begin
                            if (aw_sel.hi)
                                en_q[c][63:32] <= WDATA & SRC_MASK[63:32];
                            else
                                en_q[c][31:0] <= WDATA & SRC_MASK[31:0];
                        end
                end
                REG_THR: begin
                    for (int c = 0; c < NUM_CONTEXTS; c++)
                        if (aw_sel.ctx == 3'(c))
                            thr_q[c] <= WDATA[PRIO_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            eip <= '0;
        end else begin
            for (int c = 0; c < NUM_CONTEXTS; c++)
                eip[c] <= (best_id[c] != 6'd0);
        end
    end

    // Write channel FSM
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate <= W_IDLE;
            BVALID <= 1'b0;
        end else begin
            unique case (wstate)
                W_IDLE: if (wr_hs) begin
                    wstate <= W_RESP;
                    BVALID <= 1'b1;
                end
                W_RESP: if (BREADY) begin
                    wstate <= W_IDLE;
                    BVALID <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate <= R_IDLE;
            RVALID <= 1'b0;
            RDATA  <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: if (ARVALID) begin
                    rstate <= R_DATA;
                    RVALID <= 1'b1;
                    RDATA  <= rd_word;
                end
                R_DATA: if (RREADY) begin
                    rstate <= R_IDLE;
                    RVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_plic.sv
// tb_priority_plic: scenario tasks for priority_plic; expected read
// data is queued at issue time and popped when RDATA arrives.
module tb_priority_plic;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [30:0] irq;
    logic [1:0]  eip;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic [15:0] AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd, e;
    logic [1:0]  rr;

    priority_plic dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .irq(irq), .eip(eip),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .AWPROT(AWPROT), .WVALID(WVALID), .WREADY(WREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .BVALID(BVALID),
        .BREADY(BREADY), .BRESP(BRESP), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
        .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge ACLK);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
        int n;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
        #1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        if (!(AWREADY && WREADY)) begin
            total++; bad++;
            $display("FAIL wr_ready_timeout addr=%h", a);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!BVALID) begin
            total++; bad++;
            $display("FAIL bvalid_timeout addr=%h", a);
        end
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        #1;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
        if (!ARREADY) begin
            total++; bad++;
            $display("FAIL arready_timeout addr=%h", a);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!RVALID) begin
            total++; bad++;
            $display("FAIL rvalid_timeout addr=%h", a);
        end
        d = RDATA;
        r = RRESP;
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL rst_eip got=%b exp=00", eip);
        end
        total++;
        if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b%b exp=00", BVALID, RVALID);
        end
        total++;
        if (ARREADY !== 1'b1) begin
            bad++; $display("FAIL rst_arready got=%b exp=1", ARREADY);
        end
        exp_q.push_back(32'd0);
        axi_read(16'h0004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL rst_prio got=%h exp=%h", rd, e);
        end
    endtask

    task automatic test_level_claim();
        axi_write(16'h000C, 32'd2);
        axi_write(16'h2000, 32'h8);
        @(negedge ACLK);
        irq[2] = 1'b1;
        @(negedge ACLK);
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL lvl_eip_n1 got=%b exp=00", eip);
        end
        @(negedge ACLK);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL lvl_eip_n2 got=%b exp=01", eip);
        end
        exp_q.push_back(32'd3);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL lvl_claim got=%h exp=%h", rd, e);
        end
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL lvl_eip_claimed got=%b exp=00", eip);
        end
        axi_write(16'h8004, 32'd3);
        cycles(2);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL lvl_repend got=%b exp=01", eip);
        end
        irq[2] = 1'b0;
        exp_q.push_back(32'd3);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL lvl_claim2 got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd3);
    endtask

    task automatic test_priority();
        axi_write(16'h0014, 32'd1);
        axi_write(16'h0024, 32'd4);
        axi_write(16'h2000, 32'h220);
        @(negedge ACLK);
        irq[4] = 1'b1; irq[8] = 1'b1;
        cycles(3);
        exp_q.push_back(32'd9);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL prio_high got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd9);
        axi_write(16'h0024, 32'd1);
        cycles(2);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd9);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL prio_tie got=%h exp=%h", rd, e);
        end
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL prio_next got=%h exp=%h", rd, e);
        end
        irq[4] = 1'b0; irq[8] = 1'b0;
        axi_write(16'h8004, 32'd5);
        axi_write(16'h8004, 32'd9);
        cycles(2);
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL prio_idle_eip got=%b exp=00", eip);
        end
        exp_q.push_back(32'd0);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL prio_empty got=%h exp=%h", rd, e);
        end
    endtask

    task automatic test_threshold();
        axi_write(16'h0018, 32'd4);
        axi_write(16'h2000, 32'h40);
        axi_write(16'h8000, 32'd4);
        @(negedge ACLK);
        irq[5] = 1'b1;
        cycles(3);
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL thr_eq_eip got=%b exp=00", eip);
        end
        exp_q.push_back(32'd0);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL thr_eq_claim got=%h exp=%h", rd, e);
        end
        exp_q.push_back(32'h40);
        axi_read(16'h1000, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL thr_pending got=%h exp=%h", rd, e);
        end
        axi_write(16'h8000, 32'd3);
        cycles(1);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL thr_lt_eip got=%b exp=01", eip);
        end
        irq[5] = 1'b0;
        exp_q.push_back(32'd6);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL thr_claim got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd6);
        axi_write(16'h8000, 32'd0);
    endtask

    task automatic test_edge();
        axi_write(16'h1080, 32'h80);
        axi_write(16'h001C, 32'd3);
        axi_write(16'h2000, 32'h80);
        @(negedge ACLK); irq[6] = 1'b1;
        @(negedge ACLK); irq[6] = 1'b0;
        cycles(2);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL edge_eip got=%b exp=01", eip);
        end
        exp_q.push_back(32'd7);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL edge_claim got=%h exp=%h", rd, e);
        end
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL edge_claimed_eip got=%b exp=00", eip);
        end
        @(negedge ACLK); irq[6] = 1'b1;
        @(negedge ACLK); irq[6] = 1'b0;
        cycles(2);
        exp_q.push_back(32'h80);
        axi_read(16'h1000, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL edge_pend_inflight got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd7);
        cycles(1);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL edge_reassert got=%b exp=01", eip);
        end
        exp_q.push_back(32'd7);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL edge_claim2 got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd7);
        axi_write(16'h1080, 32'h0);
    endtask

    task automatic test_contexts();
        axi_write(16'h0008, 32'd1);
        axi_write(16'h2000, 32'h4);
        axi_write(16'h2080, 32'h4);
        @(negedge ACLK); irq[1] = 1'b1;
        @(negedge ACLK); irq[1] = 1'b0;
        cycles(2);
        total++;
        if (eip !== 2'b11) begin
            bad++; $display("FAIL ctx_both_eip got=%b exp=11", eip);
        end
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd0);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL ctx0_claim got=%h exp=%h", rd, e);
        end
        axi_read(16'h8104, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL ctx1_claim got=%h exp=%h", rd, e);
        end
        axi_write(16'h2080, 32'h0);
        axi_write(16'h8104, 32'd2);
        @(negedge ACLK); irq[1] = 1'b1;
        cycles(3);
        total++;
        if (eip !== 2'b00) begin
            bad++; $display("FAIL ctx_ignored_eip got=%b exp=00", eip);
        end
        exp_q.push_back(32'd0);
        axi_read(16'h1000, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL ctx_ignored_pend got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd2);
        cycles(2);
        total++;
        if (eip !== 2'b01) begin
            bad++; $display("FAIL ctx_complete_eip got=%b exp=01", eip);
        end
        irq[1] = 1'b0;
        exp_q.push_back(32'd2);
        axi_read(16'h8004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL ctx0_claim2 got=%h exp=%h", rd, e);
        end
        axi_write(16'h8004, 32'd2);
    endtask

    task automatic test_reg_bits();
        axi_write(16'h1080, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'h0);
        axi_read(16'h1080, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL bits_trig_lo got=%h exp=%h", rd, e);
        end
        axi_read(16'h1084, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL bits_trig_hi got=%h exp=%h", rd, e);
        end
        axi_write(16'h1080, 32'h0);
        axi_write(16'h0004, 32'hFF);
        axi_write(16'h0000, 32'h7);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h0);
        axi_read(16'h0004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL bits_prio_width got=%h exp=%h", rd, e);
        end
        axi_read(16'h0000, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL bits_prio0 got=%h exp=%h", rd, e);
        end
        axi_write(16'h0004, 32'h0);
        @(negedge ACLK);
        AWADDR = 16'h0004; WDATA = 32'h5; AWVALID = 1'b1;
        cycles(2);
        #1;
        total++;
        if (AWREADY !== 1'b0) begin
            bad++; $display("FAIL aw_only_stall got=%b exp=0", AWREADY);
        end
        AWVALID = 1'b0;
        exp_q.push_back(32'h0);
        axi_read(16'h0004, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL aw_only_nowrite got=%h exp=%h", rd, e);
        end
    endtask

    task automatic test_reset_midread();
        axi_write(16'h0008, 32'd5);
        axi_write(16'h8000, 32'd2);
        axi_write(16'h2080, 32'h4);
        @(negedge ACLK);
        RREADY = 1'b0; ARADDR = 16'h0008; ARVALID = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        total++;
        if (RVALID !== 1'b1) begin
            bad++; $display("FAIL mid_rvalid got=%b exp=1", RVALID);
        end
        #2 ARESETn = 1'b0;
        #1;
        total++;
        if (RVALID !== 1'b0 || RDATA !== 32'h0) begin
            bad++; $display("FAIL mid_rst_drop got=%b/%h exp=0/0", RVALID, RDATA);
        end
        cycles(2);
        ARESETn = 1'b1; RREADY = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        axi_read(16'h0008, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL post_rst_prio got=%h exp=%h", rd, e);
        end
        axi_read(16'h8000, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL post_rst_thr got=%h exp=%h", rd, e);
        end
        axi_read(16'h2080, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL post_rst_en got=%h exp=%h", rd, e);
        end
        axi_read(16'h7FFC, rd, rr);
        e = exp_q.pop_front();
        total++;
        if (rd !== e || rr !== 2'b00) begin
            bad++; $display("FAIL unmapped got=%h/%b exp=%h/00", rd, rr, e);
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        irq = '0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = 4'hF;
        BREADY = 1'b1;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0;
        RREADY = 1'b1;
        cycles(3);
        ARESETn = 1'b1;
        test_reset();
        test_level_claim();
        test_priority();
        test_threshold();
        test_edge();
        test_contexts();
        test_reg_bits();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
